// File: rtl/control_unit.sv
// Multicycle control FSM for the 64-bit RISC-V datapath.
// Drives every load, write, mux-select and ULA-select of the PC, IR, register bank, A/B, ALUOut, MDR and memory.
//
// state     | meaning
// ----------+---------------------------------------------
// FETCH0    | memory read at PC
// FETCH1    | load instruction register
// DECODE    | branch target into ALUOut, dispatch on opcode
// EXEC_R    | A op B into ALUOut (add/sub)
// EXEC_I    | A + imm into ALUOut
// MEM_ADDR  | A + imm into ALUOut (effective address)
// LOAD_WAIT | memory read at ALUOut
// LOAD_MDR  | capture read data in MDR
// LOAD_WB   | MDR into register bank
// STORE     | memory write at ALUOut
// BRANCH    | compare A/B, load PC from ALUOut if taken
// WB_ALU    | ALUOut into register bank
// LUI_WB    | U-immediate into register bank
// PC_INC    | PC <= PC + 4
// HALT      | unsupported instruction, sticky until reset
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       igual,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_load,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       mem_wr,
  output logic       mem_addr_sel,
  output logic       mdr_load,
  output logic       alu_out_load,
  output logic [2:0] mux_a_sel,
  output logic [2:0] mux_b_sel,
  output logic [2:0] ula_sel,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH0    = 4'd0,
    S_FETCH1    = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_LOAD_WAIT = 4'd6,
    S_LOAD_MDR  = 4'd7,
    S_LOAD_WB   = 4'd8,
    S_STORE     = 4'd9,
    S_BRANCH    = 4'd10,
    S_WB_ALU    = 4'd11,
    S_LUI_WB    = 4'd12,
    S_PC_INC    = 4'd13,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ULA_ADD = 3'd1;
  localparam logic [2:0] ULA_SUB = 3'd2;

  state_t r_state;
  state_t w_next;
  logic   w_taken;
  logic   w_branch_ok;

  assign w_taken     = ((funct3 == 3'b000) && igual) || ((funct3 == 3'b001) && !igual);
  assign w_branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign state       = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FETCH0;
    else       r_state <= w_next;
  end

  // FETCH0 drives nothing, so the async reset to FETCH0 also clears every output at once.
  always_comb begin
    w_next       = r_state;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_load      = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    mem_wr       = 1'b0;
    mem_addr_sel = 1'b0;
    mdr_load     = 1'b0;
    alu_out_load = 1'b0;
    mux_a_sel    = 3'd0;
    mux_b_sel    = 3'd0;
    ula_sel      = 3'd0;
    illegal      = 1'b0;

    unique case (r_state)
      S_FETCH0: w_next = S_FETCH1;
      S_FETCH1: begin
        ir_load = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        mux_b_sel    = 3'd3;
        ula_sel      = ULA_ADD;
        alu_out_load = 1'b1;
        case (opcode)
          OP_R:         w_next = S_EXEC_R;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_LD, OP_SD: w_next = S_MEM_ADDR;
          OP_BRANCH:    w_next = w_branch_ok ? S_BRANCH : S_HALT;
          OP_LUI:       w_next = S_LUI_WB;
          default:      w_next = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        mux_a_sel    = 3'd1;
        ula_sel      = funct7_5 ? ULA_SUB : ULA_ADD;
        alu_out_load = 1'b1;
        w_next       = S_WB_ALU;
      end
      S_EXEC_I: begin
        mux_a_sel    = 3'd1;
        mux_b_sel    = 3'd2;
        ula_sel      = ULA_ADD;
        alu_out_load = 1'b1;
        w_next       = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        mux_a_sel    = 3'd1;
        mux_b_sel    = 3'd2;
        ula_sel      = ULA_ADD;
        alu_out_load = 1'b1;
        w_next       = (opcode == OP_LD) ? S_LOAD_WAIT : S_STORE;
      end
      S_LOAD_WAIT: begin
        mem_addr_sel = 1'b1;
        w_next       = S_LOAD_MDR;
      end
      S_LOAD_MDR: begin
        mem_addr_sel = 1'b1;
        mdr_load     = 1'b1;
        w_next       = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        w_next    = S_PC_INC;
      end
      S_STORE: begin
        mem_addr_sel = 1'b1;
        mem_wr       = 1'b1;
        w_next       = S_PC_INC;
      end
      // pc_write follows igual combinationally here; every other output is state-decoded.
      S_BRANCH: begin
        mux_a_sel = 3'd1;
        ula_sel   = ULA_SUB;
        pc_src    = 1'b1;
        pc_write  = w_taken;
        w_next    = w_taken ? S_FETCH0 : S_PC_INC;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        w_next    = S_PC_INC;
      end
      S_LUI_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        w_next    = S_PC_INC;
      end
      S_PC_INC: begin
        mux_b_sel = 3'd1;
        ula_sel   = ULA_ADD;
        pc_write  = 1'b1;
        w_next    = S_FETCH0;
      end
      S_HALT: begin
        illegal = 1'b1;
        w_next  = S_HALT;
      end
      default: w_next = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios then random instructions,
// compared against per-instruction state sequences and a per-state control table.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       igual;
  logic       pc_write, pc_src, ir_load, reg_write;
  logic [1:0] wb_sel;
  logic       mem_wr, mem_addr_sel, mdr_load, alu_out_load;
  logic [2:0] mux_a_sel, mux_b_sel, ula_sel;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  control_unit dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .igual(igual), .pc_write(pc_write), .pc_src(pc_src),
    .ir_load(ir_load), .reg_write(reg_write), .wb_sel(wb_sel), .mem_wr(mem_wr),
    .mem_addr_sel(mem_addr_sel), .mdr_load(mdr_load), .alu_out_load(alu_out_load),
    .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel), .ula_sel(ula_sel),
    .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_load;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       mem_wr;
    logic       mem_addr_sel;
    logic       mdr_load;
    logic       alu_out_load;
    logic [2:0] mux_a;
    logic [2:0] mux_b;
    logic [2:0] ula;
    logic       illegal;
  } ctl_t;

  // Control word each state must present, transcribed from the state descriptions.
  function automatic ctl_t exp_ctl(input int st, input logic f7, input logic tk);
    ctl_t c;
    c = '0;
    case (st)
      1:  c.ir_load = 1'b1;
      2:  begin c.mux_b = 3'd3; c.ula = 3'd1; c.alu_out_load = 1'b1; end
      3:  begin c.mux_a = 3'd1; c.ula = f7 ? 3'd2 : 3'd1; c.alu_out_load = 1'b1; end
      4, 5: begin c.mux_a = 3'd1; c.mux_b = 3'd2; c.ula = 3'd1; c.alu_out_load = 1'b1; end
      6:  c.mem_addr_sel = 1'b1;
      7:  begin c.mem_addr_sel = 1'b1; c.mdr_load = 1'b1; end
      8:  begin c.reg_write = 1'b1; c.wb_sel = 2'd1; end
      9:  begin c.mem_addr_sel = 1'b1; c.mem_wr = 1'b1; end
      10: begin c.mux_a = 3'd1; c.ula = 3'd2; c.pc_src = 1'b1; c.pc_write = tk; end
      11: c.reg_write = 1'b1;
      12: begin c.reg_write = 1'b1; c.wb_sel = 2'd2; end
      13: begin c.mux_b = 3'd1; c.ula = 3'd1; c.pc_write = 1'b1; end
      15: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction classes: 0 R, 1 addi, 2 ld, 3 sd, 4 branch, 5 lui, 6 illegal.
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return (f3 == 3'd0 || f3 == 3'd1) ? 4 : 6;
      7'b0110111: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic void build_seq(input int cls, input logic tk, output int q[$]);
    q = '{0, 1, 2};
    case (cls)
      0: q = {q, 3, 11, 13};
      1: q = {q, 4, 11, 13};
      2: q = {q, 5, 6, 7, 8, 13};
      3: q = {q, 5, 9, 13};
      4: q = tk ? {q, 10} : {q, 10, 13};
      5: q = {q, 12, 13};
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input int st, input logic f7, input logic tk);
    ctl_t obs, exp;
    logic [3:0] exp_st;
    exp_st = st[3:0];
    exp = exp_ctl(st, f7, tk);
    obs = {pc_write, pc_src, ir_load, reg_write, wb_sel, mem_wr, mem_addr_sel,
           mdr_load, alu_out_load, mux_a_sel, mux_b_sel, ula_sel, illegal};
    n_checks++;
    assert (state === exp_st) else begin
      n_errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
    end
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s outputs(state %0d) observed=%05h expected=%05h", tag, st, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rst_async"}, 0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    check({tag, "_rst_release"}, 0, 1'b0, 1'b0);
    step();
    check({tag, "_fetch1"}, 1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs one instruction from a FETCH0 cycle; illegal ones sit in HALT then get reset.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic ig);
    int q[$];
    int cls;
    logic tk;
    opcode = op; funct3 = f3; funct7_5 = f7; igual = ig;
    cls = classify(op, f3);
    tk = ((f3 == 3'd0) && ig) || ((f3 == 3'd1) && !ig);
    build_seq(cls, tk, q);
    foreach (q[i]) begin
      check(tag, q[i], f7, tk);
      step();
    end
    if (cls == 6) begin
      for (int k = 0; k < 20; k++) begin
        check({tag, "_halt"}, 15, f7, tk);
        step();
      end
      reset_pulse(tag);
    end else begin
      check({tag, "_end"}, 0, f7, tk);
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; igual = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_hold", 0, 1'b0, 1'b0);
      @(negedge clock);
    end
    reset = 1'b0;
    check("reset_release", 0, 1'b0, 1'b0);
    step();
    check("first_fetch1", 1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;

    run_instr("r_sub",      7'b0110011, 3'd0, 1'b1, 1'b0);
    run_instr("r_add",      7'b0110011, 3'd5, 1'b0, 1'b1);
    run_instr("ld",         7'b0000011, 3'd3, 1'b0, 1'b0);
    run_instr("beq_taken",  7'b1100011, 3'd0, 1'b0, 1'b1);
    run_instr("beq_not",    7'b1100011, 3'd0, 1'b0, 1'b0);
    run_instr("bne_taken",  7'b1100011, 3'd1, 1'b0, 1'b0);
    run_instr("bne_not",    7'b1100011, 3'd1, 1'b0, 1'b1);
    run_instr("lui",        7'b0110111, 3'd0, 1'b0, 1'b0);
    run_instr("illegal_op", 7'b1111111, 3'd0, 1'b0, 1'b0);
    run_instr("bad_funct3", 7'b1100011, 3'd4, 1'b0, 1'b1);

    // Store aborted by reset: mem_wr must drop with no clock edge.
    opcode = 7'b0100011; funct3 = 3'd3; funct7_5 = 1'b0; igual = 1'b0;
    check("sd_abort", 0, 1'b0, 1'b0); step();
    check("sd_abort", 1, 1'b0, 1'b0); step();
    check("sd_abort", 2, 1'b0, 1'b0); step();
    check("sd_abort", 5, 1'b0, 1'b0); step();
    check("sd_abort_store", 9, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("sd_abort_async", 0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    check("sd_abort_release", 0, 1'b0, 1'b0);
    run_instr("sd_full", 7'b0100011, 3'd3, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int pick;
      pick = $urandom_range(0, 7);
      f3 = 3'($urandom_range(0, 7));
      case (pick)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: begin op = 7'b1100011; f3 = 3'($urandom_range(0, 1)); end
        5: op = 7'b0110111;
        6: op = 7'($urandom_range(0, 127));
        default: begin op = 7'b1100011; f3 = 3'($urandom_range(2, 7)); end
      endcase
      run_instr("random", op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
